// File: rtl/butterfly_pkg.sv
// Shared definitions for the butterfly serial-to-parallel blocks: mode encodings
// and the elaboration-time legality check on the lane count.
package butterfly_pkg;

    localparam logic MODE_LINEAR = 1'b0;
    localparam logic MODE_BFLY   = 1'b1;

    // Lane count must be a power of two between 2 and 64.
    function automatic bit lane_cnt_ok(input int n);
        return (n >= 2) && (n <= 64) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/butterfly_lane_map.sv
// Combinational slot -> lane mapping: identity in linear mode, rotation by the
// popcount of the word index in butterfly mode. Zero latency, no flow control.
module butterfly_lane_map
    import butterfly_pkg::*;
#(
    parameter int NUM_LANE = 8,
    parameter int POP_W    = 8
) (
    input  logic [$clog2(NUM_LANE)-1:0] slot,
    input  logic [POP_W-1:0]            word_idx,
    input  logic                        mode,
    output logic [$clog2(NUM_LANE)-1:0] lane
);

    localparam int LW = $clog2(NUM_LANE);

    logic [LW-1:0] pop_cnt;

    // Accumulating in LW bits gives the mod-NUM_LANE reduction for free.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < POP_W; i++) begin
            pop_cnt = pop_cnt + LW'(word_idx[i]);
        end
        lane = (mode == MODE_BFLY) ? (slot + pop_cnt) : slot;
    end

endmodule

// File: rtl/butterfly_s2p_stream.sv
// Serial-to-parallel packer, 1 element/cycle, completing element to dn_vld in 1 cycle;
// a second finished word waiting on dn_rdy stalls up_rdy. Optional BUTTERFLY_S2P_STATS_EN adds counters.
module butterfly_s2p_stream
    import butterfly_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_LANE = 8,
    parameter int CNT_W    = 32,
    parameter int POP_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CNT_W-1:0]           cfg_len,
    input  logic                       cfg_mode,
    input  logic [DATA_W-1:0]          up_dat,
    input  logic                       up_vld,
    output logic                       up_rdy,
    output logic [NUM_LANE*DATA_W-1:0] dn_dat,
    output logic [NUM_LANE-1:0]        dn_keep,
    output logic                       dn_last,
    output logic                       dn_vld,
    input  logic                       dn_rdy
`ifdef BUTTERFLY_S2P_STATS_EN
    ,
    output logic [31:0]                stat_words,
    output logic [31:0]                stat_stall
`endif
);

    localparam int LW = $clog2(NUM_LANE);
    localparam int WW = NUM_LANE * DATA_W;

    if (!lane_cnt_ok(NUM_LANE) || (LW + POP_W > CNT_W)) begin : g_bad_cfg
        $error("butterfly_s2p_stream: illegal NUM_LANE/POP_W/CNT_W combination");
    end

    logic [CNT_W-1:0]    elem_cnt;
    logic [CNT_W-1:0]    frame_len;
    logic                frame_mode;
    logic [CNT_W-1:0]    len_eff;
    logic                mode_eff;
    logic                at_bound;

    logic [WW-1:0]       asm_dat;
    logic [NUM_LANE-1:0] asm_keep;
    logic                asm_full;
    logic                asm_last;
    logic [WW-1:0]       nxt_dat;
    logic [NUM_LANE-1:0] nxt_keep;

    logic                acc;
    logic                elem_last;
    logic                word_done;
    logic                out_free;
    logic [LW-1:0]       slot;
    logic [LW-1:0]       lane;

    // Frame config is live at the boundary and frozen once the first element lands.
    assign at_bound  = (elem_cnt == '0);
    assign len_eff   = at_bound ? cfg_len  : frame_len;
    assign mode_eff  = at_bound ? cfg_mode : frame_mode;

    assign up_rdy    = !asm_full && !(at_bound && (cfg_len == '0));
    assign acc       = up_vld && up_rdy;
    assign slot      = elem_cnt[LW-1:0];
    assign elem_last = (elem_cnt == len_eff - CNT_W'(1));
    assign word_done = acc && ((slot == LW'(NUM_LANE - 1)) || elem_last);
    assign out_free  = !dn_vld || dn_rdy;

    butterfly_lane_map #(
        .NUM_LANE (NUM_LANE),
        .POP_W    (POP_W)
    ) u_lane_map (
        .slot     (slot),
        .word_idx (elem_cnt[LW +: POP_W]),
        .mode     (mode_eff),
        .lane     (lane)
    );

    always_comb begin
        nxt_dat  = asm_dat;
        nxt_keep = asm_keep;
        if (acc) begin
            nxt_dat[lane*DATA_W +: DATA_W] = up_dat;
            nxt_keep[lane]                 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt   <= '0;
            frame_len  <= '0;
            frame_mode <= MODE_LINEAR;
        end else if (acc) begin
            if (at_bound) begin
                frame_len  <= cfg_len;
                frame_mode <= cfg_mode;
            end
            elem_cnt <= elem_last ? '0 : elem_cnt + CNT_W'(1);
        end
    end

    // A completing element bypasses the assembly buffer when the output can take it,
    // so back-to-back words never cost a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_dat  <= '0;
            asm_keep <= '0;
            asm_full <= 1'b0;
            asm_last <= 1'b0;
            dn_dat   <= '0;
            dn_keep  <= '0;
            dn_last  <= 1'b0;
            dn_vld   <= 1'b0;
        end else begin
            if (out_free) begin
                dn_vld <= 1'b0;
            end
            if (asm_full) begin
                if (out_free) begin
                    dn_vld   <= 1'b1;
                    dn_dat   <= asm_dat;
                    dn_keep  <= asm_keep;
                    dn_last  <= asm_last;
                    asm_dat  <= '0;
                    asm_keep <= '0;
                    asm_full <= 1'b0;
                    asm_last <= 1'b0;
                end
            end else if (word_done) begin
                if (out_free) begin
                    dn_vld   <= 1'b1;
                    dn_dat   <= nxt_dat;
                    dn_keep  <= nxt_keep;
                    dn_last  <= elem_last;
                    asm_dat  <= '0;
                    asm_keep <= '0;
                end else begin
                    asm_dat  <= nxt_dat;
                    asm_keep <= nxt_keep;
                    asm_full <= 1'b1;
                    asm_last <= elem_last;
                end
            end else if (acc) begin
                asm_dat  <= nxt_dat;
                asm_keep <= nxt_keep;
            end
        end
    end

`ifdef BUTTERFLY_S2P_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (dn_vld && dn_rdy && (stat_words != '1)) begin
                stat_words <= stat_words + 32'd1;
            end
            if (up_vld && !up_rdy && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_butterfly_s2p_stream.sv
// Directed bench for butterfly_s2p_stream with 8 lanes of 16 bits.
module tb_butterfly_s2p_stream;

    localparam int DATA_W   = 16;
    localparam int NUM_LANE = 8;
    localparam int CNT_W    = 32;
    localparam int POP_W    = 8;
    localparam int WW       = NUM_LANE * DATA_W;

    logic              clk;
    logic              rst_n;
    logic [CNT_W-1:0]  cfg_len;
    logic              cfg_mode;
    logic [DATA_W-1:0] up_dat;
    logic              up_vld;
    logic              up_rdy;
    logic [WW-1:0]     dn_dat;
    logic [7:0]        dn_keep;
    logic              dn_last;
    logic              dn_vld;
    logic              dn_rdy;
`ifdef BUTTERFLY_S2P_STATS_EN
    logic [31:0]       stat_words;
    logic [31:0]       stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] q_dat[$];
    logic [7:0]    q_keep[$];
    logic          q_last[$];

    butterfly_s2p_stream #(
        .DATA_W   (DATA_W),
        .NUM_LANE (NUM_LANE),
        .CNT_W    (CNT_W),
        .POP_W    (POP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_len    (cfg_len),
        .cfg_mode   (cfg_mode),
        .up_dat     (up_dat),
        .up_vld     (up_vld),
        .up_rdy     (up_rdy),
        .dn_dat     (dn_dat),
        .dn_keep    (dn_keep),
        .dn_last    (dn_last),
        .dn_vld     (dn_vld),
        .dn_rdy     (dn_rdy)
`ifdef BUTTERFLY_S2P_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rst_n && dn_vld && dn_rdy) begin
            q_dat.push_back(dn_dat);
            q_keep.push_back(dn_keep);
            q_last.push_back(dn_last);
        end
    end

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] lin_word(input int base, input int n);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_LANE; k++) begin
            if (k < n) w[k*DATA_W +: DATA_W] = 16'(base + k);
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] rot_word(input int base, input int rot);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_LANE; k++) begin
            w[((k + rot) % NUM_LANE)*DATA_W +: DATA_W] = 16'(base + k);
        end
        return w;
    endfunction

    task automatic expect_word(input string tag, input logic [WW-1:0] d, input logic [7:0] k,
                               input logic l);
        check({tag, "_present"}, WW'(q_dat.size() != 0), WW'(1));
        if (q_dat.size() != 0) begin
            check({tag, "_dat"}, q_dat.pop_front(), d);
            check({tag, "_keep"}, WW'(q_keep.pop_front()), WW'(k));
            check({tag, "_last"}, WW'(q_last.pop_front()), WW'(l));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            up_dat = 16'(base + i);
            up_vld = 1'b1;
            forever begin
                @(negedge clk);
                if (up_rdy) break;
                t++;
                if (t > 200) break;
            end
            if (t > 200) begin
                check("up_rdy_wait", WW'(up_rdy), WW'(1));
                break;
            end
            @(posedge clk);
            #1;
        end
        up_vld = 1'b0;
    endtask

    task automatic clear_q();
        q_dat.delete();
        q_keep.delete();
        q_last.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_len  = 32'd16;
        cfg_mode = 1'b0;
        up_dat   = '0;
        up_vld   = 1'b0;
        dn_rdy   = 1'b1;
        idle(2);
        check("rst_dn_vld", WW'(dn_vld), WW'(0));
        check("rst_dn_last", WW'(dn_last), WW'(0));
        check("rst_dn_keep", WW'(dn_keep), WW'(0));
        check("rst_dn_dat", dn_dat, WW'(0));
        check("rst_up_rdy", WW'(up_rdy), WW'(1));
        rst_n = 1'b1;
        idle(1);

        // Linear len 16, with a config change mid-frame that must be ignored.
        clear_q();
        send_stream(0, 3);
        cfg_len  = 32'd4;
        cfg_mode = 1'b1;
        send_stream(3, 5);
        check("lin_latency_vld", WW'(dn_vld), WW'(1));
        check("lin_latency_keep", WW'(dn_keep), WW'(8'hFF));
        send_stream(8, 8);
        idle(4);
        check("lin_count", WW'(q_dat.size()), WW'(2));
        expect_word("lin_w0", 128'h0007_0006_0005_0004_0003_0002_0001_0000, 8'hFF, 1'b0);
        expect_word("lin_w1", 128'h000F_000E_000D_000C_000B_000A_0009_0008, 8'hFF, 1'b1);

        // Butterfly len 16: second word rotated by one lane.
        clear_q();
        cfg_len  = 32'd16;
        cfg_mode = 1'b1;
        send_stream(0, 16);
        idle(4);
        check("bfly16_count", WW'(q_dat.size()), WW'(2));
        expect_word("bfly16_w0", 128'h0007_0006_0005_0004_0003_0002_0001_0000, 8'hFF, 1'b0);
        expect_word("bfly16_w1", 128'h000E_000D_000C_000B_000A_0009_0008_000F, 8'hFF, 1'b1);

        // Butterfly len 32: word indices 0..3 rotate by 0,1,1,2.
        clear_q();
        cfg_len = 32'd32;
        send_stream(0, 32);
        idle(4);
        expect_word("bfly32_w0", rot_word(0, 0), 8'hFF, 1'b0);
        expect_word("bfly32_w1", rot_word(8, 1), 8'hFF, 1'b0);
        expect_word("bfly32_w2", rot_word(16, 1), 8'hFF, 1'b0);
        expect_word("bfly32_w3", rot_word(24, 2), 8'hFF, 1'b1);

        // Linear len 11: partial final word, then a second frame from slot 0.
        clear_q();
        cfg_len  = 32'd11;
        cfg_mode = 1'b0;
        send_stream(4096, 11);
        send_stream(500, 11);
        idle(4);
        expect_word("len11_w0", lin_word(4096, 8), 8'hFF, 1'b0);
        expect_word("len11_w1", 128'h0000_0000_0000_0000_0000_100A_1009_1008, 8'h07, 1'b1);
        expect_word("len11_f2w0", lin_word(500, 8), 8'hFF, 1'b0);
        expect_word("len11_f2w1", lin_word(508, 3), 8'h07, 1'b1);

        // Output held off for 20 cycles while input streams continuously.
        clear_q();
        cfg_len = 32'd24;
        dn_rdy  = 1'b0;
        fork
            send_stream(400, 24);
            begin
                idle(20);
                check("stall_up_rdy", WW'(up_rdy), WW'(0));
                check("stall_dn_vld", WW'(dn_vld), WW'(1));
                check("stall_dn_hold", dn_dat, lin_word(400, 8));
                dn_rdy = 1'b1;
            end
        join
`ifdef BUTTERFLY_S2P_STATS_EN
        check("stat_stall_5", WW'(stat_stall), WW'(5));
`endif
        idle(4);
        check("stall_count", WW'(q_dat.size()), WW'(3));
        expect_word("stall_w0", lin_word(400, 8), 8'hFF, 1'b0);
        expect_word("stall_w1", lin_word(408, 8), 8'hFF, 1'b0);
        expect_word("stall_w2", lin_word(416, 8), 8'hFF, 1'b1);

        // Reset part way through a frame.
        clear_q();
        cfg_len = 32'd16;
        send_stream(600, 5);
        rst_n = 1'b0;
        idle(2);
        check("mrst_dn_vld", WW'(dn_vld), WW'(0));
        rst_n = 1'b1;
        idle(2);
        check("mrst_no_word", WW'(q_dat.size()), WW'(0));
        send_stream(700, 16);
        idle(4);
        check("mrst_count", WW'(q_dat.size()), WW'(2));
        expect_word("mrst_w0", lin_word(700, 8), 8'hFF, 1'b0);
        expect_word("mrst_w1", lin_word(708, 8), 8'hFF, 1'b1);

        // Zero-length frame blocks input until a real length arrives.
        clear_q();
        cfg_len = 32'd0;
        up_dat  = 16'hDEAD;
        up_vld  = 1'b1;
        idle(10);
        check("len0_up_rdy", WW'(up_rdy), WW'(0));
        check("len0_no_word", WW'(q_dat.size()), WW'(0));
        up_vld  = 1'b0;
        cfg_len = 32'd8;
        idle(1);
        check("len8_up_rdy", WW'(up_rdy), WW'(1));
        send_stream(800, 8);
        idle(4);
        check("len8_count", WW'(q_dat.size()), WW'(1));
        expect_word("len8_w0", lin_word(800, 8), 8'hFF, 1'b1);
`ifdef BUTTERFLY_S2P_STATS_EN
        check("stat_words", WW'(stat_words), WW'(3));
        check("stat_stall_10", WW'(stat_stall), WW'(10));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/butterfly_s2p_stream.md
BUTTERFLY_S2P_STREAM -- requirements
Module: butterfly_s2p_stream

Interface
REQ-001 Parameter DATA_W, default 16, width of one serial element.
REQ-002 Parameter NUM_LANE, default 8, output lanes; power of two, 2..64.
REQ-003 Parameter CNT_W, default 32, width of frame length and element counter.
REQ-004 Parameter POP_W, default 8, number of word-index bits folded into the butterfly rotation.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cfg_len  in  CNT_W  elements per frame; sampled on the first accepted element of each frame.
REQ-008 cfg_mode  in  1  0 = linear lane placement, 1 = butterfly placement; sampled with cfg_len.
REQ-009 up_dat  in  DATA_W  serial input element.
REQ-010 up_vld  in  1  up_dat valid.
REQ-011 up_rdy  out  1  block can accept up_dat this cycle.
REQ-012 dn_dat  out  NUM_LANE*DATA_W  parallel word; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-013 dn_keep  out  NUM_LANE  per-lane written mask.
REQ-014 dn_last  out  1  word is the final word of its frame.
REQ-015 dn_vld  out  1  dn_dat/dn_keep/dn_last valid.
REQ-016 dn_rdy  in  1  downstream accepts this cycle.

Function
REQ-017 An element transfers on up_vld && up_rdy; a word transfers on dn_vld && dn_rdy; dn_* shall stay stable while dn_vld && !dn_rdy.
REQ-018 The element counter e shall run 0..len-1 and wrap to 0 after the element e == len-1 transfers.
REQ-019 Terms: L = log2(NUM_LANE), slot = e[L-1:0], word index w = e >> L.
REQ-020 Linear mode: target lane = slot.
REQ-021 Butterfly mode: target lane = (slot + popcount(w[POP_W-1:0])) mod NUM_LANE.
REQ-022 The assembly buffer shall write up_dat into the target lane and set that lane's keep bit.
REQ-023 The word is complete when slot == NUM_LANE-1 or e == len-1.
REQ-024 A complete word shall move to the output register in the cycle after completion if the output register is empty or drains that cycle; otherwise it is held in the assembly buffer.
REQ-025 up_rdy shall be 0 while the assembly buffer holds a complete word, and 1 otherwise.
REQ-026 Sustained throughput shall be 1 element/cycle when dn_rdy is held at 1.
REQ-027 Latency from the transfer of the completing element to dn_vld shall be 1 cycle when the output register is free.
REQ-028 Partial final word: lanes not written shall be driven to 0 with dn_keep = 0, and dn_last = 1.
REQ-029 dn_last shall be 1 only on the word that contains element len-1.
REQ-030 cfg_len == 0 shall force up_rdy = 0 at a frame boundary; no element is accepted and the counter holds.
REQ-031 Changes to cfg_len or cfg_mode in mid-frame shall be ignored until the next frame.
REQ-032 No element shall be lost or duplicated under any up_vld/dn_rdy pattern.

Reset
REQ-033 On rst_n low the block shall clear the counter, assembly buffer, keep bits and output register.
REQ-034 Reset values: dn_vld=0, dn_last=0, dn_keep=0, dn_dat=0, up_rdy=1 (0 if cfg_len==0).
REQ-035 Reset asserted in mid-frame shall discard the partial frame; the first element after reset starts a new frame.

Configuration
REQ-036 With macro BUTTERFLY_S2P_STATS_EN defined, the block shall add outputs stat_words [31:0] and stat_stall [31:0].
REQ-037 stat_words shall count words transferred on dn; stat_stall shall count cycles with up_vld && !up_rdy.
REQ-038 The stat counters shall saturate at all-ones and reset to 0.
REQ-039 Without BUTTERFLY_S2P_STATS_EN, the stat ports and counters shall be absent.

Structure
REQ-040 Shared package butterfly_pkg shall hold the mode encoding constants (MODE_LINEAR=0, MODE_BFLY=1) and the lane-count legality check.
REQ-041 The combinational lane-mapping function (slot, w, mode -> lane) shall be the sub-module butterfly_lane_map, reused by the butterfly consumers.

Verification
REQ-042 Linear mode, len=16, NUM_LANE=8, elements 0..15, dn_rdy=1 -> two words with lane k=k then k=8+k, keep=0xFF, dn_last on word 2 only.
REQ-043 Butterfly mode, len=16 -> word 0 with lane k=k; word 1 (popcount=1) with lane (k+1)%8 = 8+k, i.e. lane0=15, lane1=8.
REQ-044 len=11 linear -> word 1 has keep=0x07, lanes 3..7=0, dn_last=1; the next frame starts at slot 0.
REQ-045 Continuous input with dn_rdy low for 20 cycles -> up_rdy drops after the second complete word, stat_stall increments per stalled cycle, and all data arrives in order once dn_rdy=1.
REQ-046 Reset pulse after 5 of 16 elements -> no dn_vld from the partial frame; the following 16 elements produce two correct words.
REQ-047 cfg_len=0 -> up_rdy=0 and no transfers; cfg_len set to 8 -> acceptance resumes and one full word has dn_last=1.
